// File: rtl/pwm_state_channel_if.sv
// Channel bundle for one colour-wheel PWM channel.
// The channel drives the tick/state/pwm outputs; the consumer drives initial_state.
interface pwm_state_channel_if;
  logic [2:0] initial_state;
  logic       ms_tick;
  logic [2:0] current_state;
  logic       variable_duty_pwm;

  modport master (
    input  initial_state,
    output ms_tick,
    output current_state,
    output variable_duty_pwm
  );

  modport slave (
    output initial_state,
    input  ms_tick,
    input  current_state,
    input  variable_duty_pwm
  );
endinterface

// File: rtl/pwm_state_channel.sv
// One colour channel: six-state wheel timebase, duty ramp engine, PWM output.
// Option macro PWM_STATE_CHANNEL_ACTIVE_LOW_EN makes the PWM output active-low.
module pwm_state_channel #(
  parameter int INC_DEC_INTERVAL = 10_000,
  parameter int INC_DEC_MAX      = 200,
  parameter int STATE_COUNT      = 6,
  parameter int PWM_INTERVAL     = 1200,
  parameter int STEP_VAL         =
    (PWM_INTERVAL / INC_DEC_MAX > 1) ?
    (PWM_INTERVAL / INC_DEC_MAX) : 1
) (
  input logic clk,
  input logic rst_n,
  pwm_state_channel_if.master bus
);

  localparam int CW =
    (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
  localparam int TW =
    (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;
  localparam int DW = $clog2(PWM_INTERVAL + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(INC_DEC_INTERVAL - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(INC_DEC_MAX - 1);
  localparam logic [DW-1:0] PCNT_LAST = DW'(PWM_INTERVAL - 1);
  localparam logic [DW-1:0] FULL = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP = DW'(STEP_VAL);
  localparam logic [2:0]    ST_LAST = 3'(STATE_COUNT - 1);
  localparam logic [2:0]    ST_CNT = 3'(STATE_COUNT);

`ifdef PWM_STATE_CHANNEL_ACTIVE_LOW_EN
  localparam logic PWM_INV = 1'b1;
`else
  localparam logic PWM_INV = 1'b0;
`endif

  logic [CW-1:0] r_cyc;
  logic          r_ms_tick;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_state;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] r_pcnt;
  logic          r_pwm;

  logic [2:0]    w_init;
  logic [DW-1:0] w_init_duty;
  logic          w_adv;
  logic [2:0]    w_state_nxt;
  logic [DW-1:0] w_target;
  logic          w_ramp;
  logic [DW-1:0] w_duty_nxt;

  assign w_init = (bus.initial_state < ST_CNT) ?
                  bus.initial_state : 3'd0;
  assign w_adv  = r_ms_tick && (r_tcnt == TCNT_LAST);

  // Duty a state starts with: high plateau/ramp-down states begin full.
  always_comb begin
    w_init_duty = '0;
    unique case (w_init)
      3'd1, 3'd2, 3'd3: w_init_duty = FULL;
      default:          w_init_duty = '0;
    endcase
  end

  // Cycle and tick timebase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc     <= '0;
      r_ms_tick <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      if (r_cyc == CYC_LAST) begin
        r_cyc     <= '0;
        r_ms_tick <= 1'b1;
      end else begin
        r_cyc     <= r_cyc + 1'b1;
        r_ms_tick <= 1'b0;
      end
      if (r_ms_tick)
        r_tcnt <= (r_tcnt == TCNT_LAST) ? '0 : r_tcnt + 1'b1;
    end
  end

  // Colour-wheel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= w_init;
    else        r_state <= w_state_nxt;
  end

  // Next state: advance once per full tick count.
  always_comb begin
    w_state_nxt = r_state;
    if (w_adv)
      w_state_nxt = (r_state == ST_LAST) ? 3'd0 : r_state + 3'd1;
  end

  // Per-state target duty and ramp enable.
  always_comb begin
    w_target = '0;
    w_ramp   = 1'b0;
    unique case (r_state)
      3'd0: begin w_target = FULL; w_ramp = 1'b1; end
      3'd1: begin w_target = FULL; w_ramp = 1'b0; end
      3'd2: begin w_target = FULL; w_ramp = 1'b0; end
      3'd3: begin w_target = '0;   w_ramp = 1'b1; end
      default: begin w_target = '0; w_ramp = 1'b0; end
    endcase
  end

  // Duty step toward target, clamped so it lands exactly on it.
  always_comb begin
    w_duty_nxt = r_duty;
    if (!w_ramp) begin
      w_duty_nxt = w_target;
    end else if (r_ms_tick) begin
      if (r_duty < w_target)
        w_duty_nxt = (w_target - r_duty > STEP) ?
                     r_duty + STEP : w_target;
      else if (r_duty > w_target)
        w_duty_nxt = (r_duty - w_target > STEP) ?
                     r_duty - STEP : w_target;
    end
  end

  // Duty register and free-running PWM period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= w_init_duty;
      r_pcnt <= '0;
    end else begin
      r_duty <= w_duty_nxt;
      r_pcnt <= (r_pcnt == PCNT_LAST) ? '0 : r_pcnt + 1'b1;
    end
  end

  // Registered PWM compare; lags duty by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm <= PWM_INV;
    else        r_pwm <= (r_pcnt < r_duty) ^ PWM_INV;
  end

  assign bus.ms_tick           = r_ms_tick;
  assign bus.current_state     = r_state;
  assign bus.variable_duty_pwm = r_pwm;

endmodule

// File: tb/tb_pwm_state_channel.sv
// Bench for pwm_state_channel with a shrunk timebase.
// Vector table plus a scoreboard queue, and cycle sequences for ticks/PWM/reset.
module tb_pwm_state_channel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

`ifdef PWM_STATE_CHANNEL_ACTIVE_LOW_EN
  localparam int INV = 1;
`else
  localparam int INV = 0;
`endif

  pwm_state_channel_if bus ();

  pwm_state_channel #(
    .INC_DEC_INTERVAL(4),
    .INC_DEC_MAX(5),
    .STATE_COUNT(6),
    .PWM_INTERVAL(10),
    .STEP_VAL(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int init;
    int k;
    int st;
    int duty;
  } vec_t;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int act);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk(e.name, act, e.val);
    end
  endtask

  task automatic do_reset(input int init);
    @(negedge clk);
    rst_n = 1'b0;
    bus.initial_state = 3'(init);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic run(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Duty after k edges from release with initial_state 0 (k < 41).
  function automatic int duty0(input int k);
    int d;
    if (k < 1) return 0;
    d = 2 * ((k - 1) / 4);
    return (d > 10) ? 10 : d;
  endfunction

  initial begin
    bus.initial_state = 3'd0;
    // {initial_state, edges after release, state, duty}
    tbl.push_back('{4,   0, 4,  0});
    tbl.push_back('{4,  20, 4,  0});
    tbl.push_back('{4,  21, 5,  0});
    tbl.push_back('{0,   4, 0,  0});
    tbl.push_back('{0,   5, 0,  2});
    tbl.push_back('{0,   9, 0,  4});
    tbl.push_back('{0,  17, 0,  8});
    tbl.push_back('{0,  21, 1, 10});
    tbl.push_back('{3,   0, 3, 10});
    tbl.push_back('{3,   5, 3,  8});
    tbl.push_back('{3,  17, 3,  2});
    tbl.push_back('{3,  21, 4,  0});
    tbl.push_back('{5,  21, 0,  0});
    tbl.push_back('{5,  41, 1, 10});
    tbl.push_back('{5,  81, 3, 10});
    tbl.push_back('{5, 101, 4,  0});
    tbl.push_back('{5, 121, 5,  0});
    tbl.push_back('{2,   0, 2, 10});
    tbl.push_back('{6,   0, 0,  0});
    tbl.push_back('{7,  21, 1, 10});

    foreach (tbl[i]) begin
      do_reset(tbl[i].init);
      sb.push_back('{$sformatf("vec%0d_state", i), tbl[i].st});
      sb.push_back('{$sformatf("vec%0d_duty", i), tbl[i].duty});
      run(tbl[i].k);
      pop_chk(int'(bus.current_state));
      pop_chk(int'(dut.r_duty));
    end

    // Reset values while held in reset.
    @(negedge clk);
    rst_n = 1'b0;
    bus.initial_state = 3'd4;
    #1;
    chk("rst_tick", int'(bus.ms_tick), 0);
    chk("rst_pwm", int'(bus.variable_duty_pwm), INV);
    chk("rst_state", int'(bus.current_state), 4);

    // Tick cadence and constant-low PWM in state 4.
    do_reset(4);
    for (int k = 1; k <= 24; k++) begin
      sb.push_back('{$sformatf("tick_k%0d", k), (k % 4 == 0) ? 1 : 0});
      sb.push_back('{$sformatf("pwm4_k%0d", k), INV});
      run(1);
      pop_chk(int'(bus.ms_tick));
      pop_chk(int'(bus.variable_duty_pwm));
    end

    // PWM follows ramping duty in state 0, then constant high in state 1.
    do_reset(0);
    for (int k = 1; k <= 40; k++) begin
      int e;
      e = (((k - 1) % 10) < duty0(k - 1)) ? 1 : 0;
      sb.push_back('{$sformatf("pwm0_k%0d", k), e ^ INV});
      run(1);
      pop_chk(int'(bus.variable_duty_pwm));
    end

    // Asynchronous reset mid-ramp, then restart from zero.
    do_reset(0);
    run(16);
    chk("mid_duty", int'(dut.r_duty), 6);
    chk("mid_tick", int'(bus.ms_tick), 1);
    chk("mid_pwm", int'(bus.variable_duty_pwm), 1 ^ INV);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", int'(bus.ms_tick), 0);
    chk("arst_pwm", int'(bus.variable_duty_pwm), INV);
    chk("arst_state", int'(bus.current_state), 0);
    chk("arst_duty", int'(dut.r_duty), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3);
    chk("restart_notick", int'(bus.ms_tick), 0);
    run(1);
    chk("restart_tick", int'(bus.ms_tick), 1);
    run(1);
    chk("restart_duty", int'(dut.r_duty), 2);

    // Plateau state 1: full duty, PWM constant active.
    do_reset(1);
    for (int k = 1; k <= 10; k++) begin
      run(1);
      chk($sformatf("pwm1_k%0d", k),
          int'(bus.variable_duty_pwm), 1 ^ INV);
    end

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
